// File: rtl/lcd_sprite_overlay.sv
// lcd_sprite_overlay
// Draws an IMG_W x IMG_H sprite, read from an external synchronous ROM, over a
// constant background at a runtime position. When move_en is set the sprite
// bounces inside the active area, one step per frame on the lcd_vs rising edge.
// Pixel path latency is fixed at 3 pclk; de_out is delayed to match pixel_data.
// Optional build macro: LCD_SPRITE_KEY_EN makes KEY_COLOR sprite pixels transparent.
module lcd_sprite_overlay #(
    parameter int IMG_W  = 30,
    parameter int IMG_H  = 30,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 24,
    parameter int X0     = 200,
    parameter int Y0     = 100,
    parameter int STEP   = 4,
    parameter logic [DATA_W-1:0] BG_COLOR  = 24'h000000,
    parameter logic [DATA_W-1:0] KEY_COLOR = 24'hFF00FF
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              lcd_vs,
    input  logic              de_in,
    input  logic [10:0]       pixel_row,
    input  logic [10:0]       pixel_line,
    input  logic [10:0]       h_disp,
    input  logic [10:0]       v_disp,
    input  logic              move_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] pixel_data,
    output logic              de_out
);

    localparam logic [11:0] IMG_W12 = 12'(IMG_W);
    localparam logic [11:0] IMG_H12 = 12'(IMG_H);
    localparam logic [11:0] STEP12  = 12'(STEP);

`ifdef LCD_SPRITE_KEY_EN
    localparam logic KEY_EN = 1'b1;
`else
    localparam logic KEY_EN = 1'b0;
`endif

    // One bounce step on one axis; returns {new_dir, new_pos}. Sums are 12 bit
    // so pos + STEP + IMG never wraps for 11-bit coordinates.
    function automatic logic [11:0] bounce_step(
        input logic [10:0] pos,
        input logic        dir,
        input logic [10:0] disp,
        input logic [11:0] img
    );
        logic [11:0] p;
        logic [11:0] d;
        logic [11:0] res;
        p = {1'b0, pos};
        d = {1'b0, disp};
        if (d < img) begin
            res = {dir, 11'd0};
        end else if (!dir) begin
            if ((p + STEP12 + img) <= d) begin
                res = {1'b0, 11'(p + STEP12)};
            end else begin
                res = {1'b1, 11'(d - img)};
            end
        end else begin
            if (p >= STEP12) begin
                res = {1'b1, 11'(p - STEP12)};
            end else begin
                res = {1'b0, 11'd0};
            end
        end
        return res;
    endfunction

    logic              vs_d_r;
    logic              frame_tick_s;
    logic [10:0]       x_pos_r, y_pos_r;
    logic              dir_x_r, dir_y_r;
    logic [10:0]       x_nxt_s, y_nxt_s;
    logic              dir_x_nxt_s, dir_y_nxt_s;

    logic [11:0]       row12_s, line12_s, x12_s, y12_s;
    logic              hit_s;
    logic [10:0]       dx_s, dy_s;
    logic [ADDR_W-1:0] addr_s;

    logic              hit1_r, de1_r, hit2_r, de2_r;
    logic [ADDR_W-1:0] rom_addr_r;
    logic [DATA_W-1:0] pixel_r;
    logic              de_out_r;
    logic              key_hit_s;
    logic [DATA_W-1:0] pix_nxt_s;

    assign frame_tick_s = lcd_vs & ~vs_d_r;

    // Next sprite position: only moves on a frame tick with move_en set.
    always_comb begin
        x_nxt_s     = x_pos_r;
        y_nxt_s     = y_pos_r;
        dir_x_nxt_s = dir_x_r;
        dir_y_nxt_s = dir_y_r;
        if (frame_tick_s && move_en) begin
            {dir_x_nxt_s, x_nxt_s} = bounce_step(x_pos_r, dir_x_r, h_disp, IMG_W12);
            {dir_y_nxt_s, y_nxt_s} = bounce_step(y_pos_r, dir_y_r, v_disp, IMG_H12);
        end else begin
            x_nxt_s     = x_pos_r;
            y_nxt_s     = y_pos_r;
            dir_x_nxt_s = dir_x_r;
            dir_y_nxt_s = dir_y_r;
        end
    end

    // Vsync edge detector and sprite position/direction registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_r  <= 1'b0;
            x_pos_r <= 11'(X0);
            y_pos_r <= 11'(Y0);
            dir_x_r <= 1'b0;
            dir_y_r <= 1'b0;
        end else begin
            vs_d_r  <= lcd_vs;
            x_pos_r <= x_nxt_s;
            y_pos_r <= y_nxt_s;
            dir_x_r <= dir_x_nxt_s;
            dir_y_r <= dir_y_nxt_s;
        end
    end

    // S1 window test and row-major ROM address (truncated to ADDR_W).
    always_comb begin
        row12_s  = {1'b0, pixel_row};
        line12_s = {1'b0, pixel_line};
        x12_s    = {1'b0, x_pos_r};
        y12_s    = {1'b0, y_pos_r};
        hit_s    = de_in
                 & (row12_s  >= x12_s) & (row12_s  <= (x12_s + IMG_W12 - 12'd1))
                 & (line12_s >= y12_s) & (line12_s <= (y12_s + IMG_H12 - 12'd1));
        dx_s     = pixel_row  - x_pos_r;
        dy_s     = pixel_line - y_pos_r;
        addr_s   = ADDR_W'(dx_s) + (ADDR_W'(dy_s) * ADDR_W'(IMG_W));
    end

    // S3 colour select; keyed pixels fall through to the background.
    always_comb begin
        key_hit_s = KEY_EN & (rom_data == KEY_COLOR);
        pix_nxt_s = BG_COLOR;
        if (hit2_r && !key_hit_s) begin
            pix_nxt_s = rom_data;
        end else begin
            pix_nxt_s = BG_COLOR;
        end
    end

    // Three-stage pixel pipeline: address, ROM read, colour output.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hit1_r     <= 1'b0;
            de1_r      <= 1'b0;
            hit2_r     <= 1'b0;
            de2_r      <= 1'b0;
            rom_addr_r <= '0;
            pixel_r    <= BG_COLOR;
            de_out_r   <= 1'b0;
        end else begin
            hit1_r     <= hit_s;
            de1_r      <= de_in;
            rom_addr_r <= hit_s ? addr_s : rom_addr_r;
            hit2_r     <= hit1_r;
            de2_r      <= de1_r;
            pixel_r    <= pix_nxt_s;
            de_out_r   <= de2_r;
        end
    end

    assign rom_addr   = rom_addr_r;
    assign pixel_data = pixel_r;
    assign de_out     = de_out_r;

endmodule
